fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
// - Shares the single write port of the async FIFO among NREQ producers in the write-clock domain.
// - Grants one producer at a time for a burst of up to BURST words; arbitration is round-robin.
// - Drives the FIFO winc/wdata and honours wfull back-pressure; it never writes into a full FIFO.
// - Sits between the producer blocks and the write side of the async FIFO top.
// PARAMETERS
// - NREQ   default 4  number of producers, 2..8
// - DSIZE  default 8  data width; must match the FIFO DSIZE
// - BURST  default 4  maximum words per grant, 1..16
// PORTS
// - wclk      in   1            write clock; the only clock
// - wrst_n    in   1            asynchronous active-low reset
// - req_valid in   NREQ         producer i has a word on req_data slice i
// - req_data  in   NREQ*DSIZE   producer data; slice i = [i*DSIZE +: DSIZE]
// - req_ready out  NREQ         one-hot or zero; a word transfers when req_valid[i] && req_ready[i]
// - wfull     in   1            FIFO full flag (wclk domain)
// - winc      out  1            FIFO write enable
// - wdata     out  DSIZE        FIFO write data
// - gnt_id    out  $clog2(NREQ) index of the granted producer; holds its value when idle
// - busy      out  1            1 while in XFER
// BEHAVIOUR
// - Reset (async, wrst_n=0):
//   - state=IDLE, beat_cnt=0, gnt_id=0, last=NREQ-1 (so producer 0 wins first).
//   - req_ready=0, winc=0, busy=0, wdata=0.
//   - A reset in mid-burst aborts the burst; no partial state survives.
// - FSM IDLE:
//   - req_ready=0, winc=0.
//   - If any req_valid is set, pick the first set bit searching from last+1 upward with wrap.
//   - Register that index into gnt_id, clear beat_cnt, and go to XFER.
//   - Arbitration latency is 1 cycle from req_valid to the first possible transfer.
// - FSM XFER (g = gnt_id):
//   - req_ready[g] = !wfull; all other ready bits are 0.
//   - winc = req_valid[g] && !wfull; wdata = req_data[g]. Both are combinational from the registered gnt_id.
//   - On each transfer, beat_cnt increments.
//   - XFER -> IDLE, with last <= g, when either:
//     - a transfer occurs with beat_cnt == BURST-1, or
//     - req_valid[g] == 0 in any cycle (the producer released early).
//   - wfull=1 stalls the burst: the grant is held, winc=0, and beat_cnt is unchanged. There is no timeout.
//   - wfull and req_valid[g] are both sampled each cycle; a drop of req_valid while full still releases the grant.
// - After any release the controller spends one IDLE cycle. Back-to-back bursts therefore have a 1-cycle bubble.
// - Fairness:
//   - A producer that wins is searched last in the next arbitration.
//   - Worst-case wait is (NREQ-1) bursts plus bubbles.
// - Widths:
//   - beat_cnt is $clog2(BURST+1) bits and never wraps past BURST-1.
//   - gnt_id and last wrap modulo NREQ.
// - winc is never 1 while wfull=1. This must hold in every state.
// CONFIGURATION
// - `define FIFO_WR_ARB_FIXED_PRIO_EN:
//   - Arbitration is fixed priority: the lowest set index of req_valid wins.
//   - last is ignored, and starvation of high indices is allowed.
// - Macro not defined:
//   - Round-robin from last+1 as described above.
//   - All other behaviour is identical in both builds.
// TESTING
// - Reset, then req_valid=4'b0001 holding 6 words, wfull=0:
//   - gnt_id=0 and busy=1 one cycle later.
//   - Four winc pulses on consecutive cycles, then one IDLE cycle.
//   - Then a second grant to 0 for the remaining 2 words.
// - req_valid=4'b1111 held continuously:
//   - Grant order is 0,1,2,3,0, each grant lasting 4 beats with a 1-cycle bubble between grants.
//   - With FIFO_WR_ARB_FIXED_PRIO_EN the order is 0,0,0...
// - Producer 2 granted, wfull=1 after beat 2 for 5 cycles:
//   - winc=0 and req_ready=0 during the stall; gnt_id stays 2.
//   - Beats 3-4 complete when wfull falls; no data is lost or duplicated (scoreboard against the FIFO).
// - Producer 1 granted, req_valid[1] drops after 1 beat:
//   - Next cycle is IDLE and the grant moves to the next requester; beat_cnt restarts at 0.
// - wrst_n pulsed low mid-burst (gnt_id=3, beat 2):
//   - All outputs are 0 immediately (asynchronously).
//   - After release, producer 0 wins first.
// - Assertions run for the whole regression:
//   - !(winc && wfull).
//   - $onehot0(req_ready).
//   - winc == |(req_valid & req_ready).

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the arbiter and the async FIFO.
// The master modport is the arbiter's view; the slave modport is the
// producers' and FIFO's view.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IW-1:0]         gnt_id;
  logic                  busy;

  modport master (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, gnt_id, busy
  );

  modport slave (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, gnt_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Shares the single async-FIFO write port among NREQ producers in the
// write-clock domain. One producer holds the port for a burst of up to
// BURST words; wfull stalls the burst and the FIFO is never written while
// full. A release always costs one IDLE cycle before the next grant.
// Build option: define FIFO_WR_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); otherwise arbitration is round-robin.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic              wclk,
  input  logic              wrst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NREQ - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   gnt_id, gnt_n, pick;
  logic [CW-1:0]   beat_cnt, beat_n;
  logic            release_g;
  logic [NREQ-1:0] ready;
  logic            winc;
  logic [DSIZE-1:0] wdata;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index wins; scan downward so the
  // last assignment is the lowest set bit.
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) pick = IW'(i);
    end
  end
`else
  logic [IW-1:0] last;

  // Round-robin: the nearest requester after last wins, last itself is
  // searched last. Scanning from the far end keeps the nearest one.
  always_comb begin
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(last) + k) % NREQ]) pick = IW'((int'(last) + k) % NREQ);
    end
  end

  // Remember the most recently released winner for the next search.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)        last <= LAST_ID;
    else if (release_g) last <= gnt_id;
  end
`endif

  // State, grant and beat-count registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      gnt_id   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt_id   <= gnt_n;
      beat_cnt <= beat_n;
    end
  end

  // Next-state and handshake outputs; XFER outputs come straight from the
  // registered gnt_id so a stall or an early drop is seen in the same cycle.
  // NOTE: every output of this block is defaulted first so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt_id;
    beat_n    = beat_cnt;
    release_g = 1'b0;
    ready     = '0;
    winc      = 1'b0;
    wdata     = '0;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          gnt_n   = pick;
          beat_n  = '0;
          state_n = XFER;
        end
      end
      XFER: begin
        ready[gnt_id] = !bus.wfull;
        winc          = bus.req_valid[gnt_id] && !bus.wfull;
        wdata         = bus.req_data[int'(gnt_id) * DSIZE +: DSIZE];
        if (!bus.req_valid[gnt_id]) begin
          release_g = 1'b1;
        end else if (winc) begin
          if (beat_cnt == LAST_BEAT) release_g = 1'b1;
          else                       beat_n    = beat_cnt + 1'b1;
        end
        if (release_g) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.winc      = winc;
  assign bus.wdata     = wdata;
  assign bus.gnt_id    = gnt_id;
  assign bus.busy      = (state == XFER);
endmodule
